// File: rtl/wb_drain_queue_pkg.sv
// Shared types for the writeback drain queue: register-write entry and r0 helper.
package wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   function automatic logic is_r0(input logic [REG_ADDR_W-1:0] addr);
      return addr == '0;
   endfunction
endpackage

// File: rtl/wb_drain_queue_if.sv
// Execute-result, regfile-write and hazard-lookup bundle around wb_drain_queue.
interface wb_drain_queue_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
);
   import wb_pkg::*;
   logic                  res_valid_0, res_valid_1, res_ready;
   logic [REG_ADDR_W-1:0] res_addr_0, res_addr_1;
   logic [DATA_W-1:0]     res_data_0, res_data_1;
   logic                  wb_stall;
   logic                  we_1, we_2;
   logic [REG_ADDR_W-1:0] writeaddr_1, writeaddr_2;
   logic [DATA_W-1:0]     writedata_1, writedata_2;
   logic [REG_ADDR_W-1:0] pend_addr_0, pend_addr_1;
   logic                  pend_hit_0, pend_hit_1;
   logic [CNT_W-1:0]      count;

   modport master (
      output res_valid_0, res_addr_0, res_data_0, res_valid_1, res_addr_1, res_data_1,
      output wb_stall, pend_addr_0, pend_addr_1,
      input  res_ready, we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2,
      input  pend_hit_0, pend_hit_1, count
   );
   modport slave (
      input  res_valid_0, res_addr_0, res_data_0, res_valid_1, res_addr_1, res_data_1,
      input  wb_stall, pend_addr_0, pend_addr_1,
      output res_ready, we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2,
      output pend_hit_0, pend_hit_1, count
   );
endinterface

// File: rtl/wb_drain_queue_fifo_2w2r.sv
// Circular buffer with 0..2 pushes and 0..2 pops per cycle; exposes the two head
// entries, the whole storage array and a live-entry mask for hazard lookup.
module wb_fifo_2w2r
   import wb_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             push_n,
   input  wb_entry_t              push0,
   input  wb_entry_t              push1,
   input  logic [1:0]             pop_n,
   output wb_entry_t              head0,
   output wb_entry_t              head1,
   output logic [CNT_W-1:0]       count,
   output logic [DEPTH-1:0]       live,
   output wb_entry_t [DEPTH-1:0]  ents
);
   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] head_p1, tail_p1;

   assign head_p1 = head_q + PTR_W'(1);
   assign tail_p1 = tail_q + PTR_W'(1);

   // Storage is not reset; only the live window is ever observed.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) mem[tail_q]  <= push0;
      if (push_n == 2'd2) mem[tail_p1] <= push1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PTR_W'(pop_n);
         tail_q  <= tail_q + PTR_W'(push_n);
         count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      end
   end

   assign head0 = mem[head_q];
   assign head1 = mem[head_p1];
   assign count = count_q;

   always_comb begin
      live = '0;
      ents = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ents[i] = mem[i];
         live[i] = {1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q;
      end
   end
endmodule

// File: rtl/wb_drain_queue.sv
// In-order dual-lane writeback queue draining two regfile writes per cycle.
// Optional zero-latency bypass when the queue is (nearly) empty: WB_DRAIN_BYPASS_EN.
module wb_drain_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   wb_drain_queue_if.slave bus
);
   localparam int NUM_LANES = 2;

   wb_entry_t             head0, head1, first, lane1;
   wb_entry_t             push0, push1, wr1, wr2;
   wb_entry_t [DEPTH-1:0] ents;
   logic [DEPTH-1:0]      live;
   logic [CNT_W-1:0]      cnt;
   logic [1:0]            push_n, pop_n, n_acc;
   logic                  ready, acc0, acc1, we1, we2;

   // Credit only the registered occupancy, never this cycle's drain.
   assign ready = rst && (cnt <= CNT_W'(DEPTH - 2));
   assign acc0  = ready && bus.res_valid_0 && !is_r0(bus.res_addr_0);
   assign acc1  = ready && bus.res_valid_1 && !is_r0(bus.res_addr_1);
   assign n_acc = {1'b0, acc0} + {1'b0, acc1};
   assign lane1 = '{addr: bus.res_addr_1, data: bus.res_data_1};
   assign first = acc0 ? wb_entry_t'{addr: bus.res_addr_0, data: bus.res_data_0} : lane1;

   always_comb begin
      push_n = n_acc;
      push0  = first;
      push1  = lane1;
      pop_n  = 2'd0;
      we1    = 1'b0;
      we2    = 1'b0;
      wr1    = head0;
      wr2    = head1;
      if (!bus.wb_stall) begin
         if (cnt >= CNT_W'(2)) begin
            we1   = 1'b1;
            we2   = 1'b1;
            pop_n = 2'd2;
         end else if (cnt == CNT_W'(1)) begin
            we1   = 1'b1;
            pop_n = 2'd1;
         end
      end
`ifdef WB_DRAIN_BYPASS_EN
      if (!bus.wb_stall && cnt == '0) begin
         push_n = 2'd0;
         we1    = n_acc != 2'd0;
         wr1    = first;
         we2    = n_acc == 2'd2;
         wr2    = lane1;
      end else if (!bus.wb_stall && cnt == CNT_W'(1) && n_acc != 2'd0) begin
         // Oldest incoming lane rides port 2 behind the head; any second lane queues.
         we2    = 1'b1;
         wr2    = first;
         push_n = n_acc - 2'd1;
         push0  = lane1;
      end
`endif
   end

   wb_fifo_2w2r #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_n (push_n),
      .push0  (push0),
      .push1  (push1),
      .pop_n  (pop_n),
      .head0  (head0),
      .head1  (head1),
      .count  (cnt),
      .live   (live),
      .ents   (ents)
   );

   assign bus.res_ready   = ready;
   assign bus.count       = cnt;
   assign bus.we_1        = rst && we1;
   assign bus.we_2        = rst && we2;
   assign bus.writeaddr_1 = bus.we_1 ? wr1.addr : '0;
   assign bus.writedata_1 = bus.we_1 ? wr1.data : '0;
   assign bus.writeaddr_2 = bus.we_2 ? wr2.addr : '0;
   assign bus.writedata_2 = bus.we_2 ? wr2.data : '0;

   logic [NUM_LANES-1:0][REG_ADDR_W-1:0] pend_addr;
   logic [NUM_LANES-1:0]                 pend_hit;
   assign pend_addr = {bus.pend_addr_1, bus.pend_addr_0};

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_hz
      logic [DEPTH-1:0] match;
      always_comb begin
         match = '0;
         for (int e = 0; e < DEPTH; e++)
            match[e] = live[e] && (ents[e].addr == pend_addr[l]);
      end
      assign pend_hit[l] = rst && !is_r0(pend_addr[l]) && (|match);
   end

   assign bus.pend_hit_0 = pend_hit[0];
   assign bus.pend_hit_1 = pend_hit[1];
endmodule

// File: doc/wb_drain_queue.md
Name: wb_drain_queue

Overview:
- In-order writeback queue feeding the dual-write-port register file.
- Accepts up to two completed results per cycle from the two execute lanes, buffers them in program order, and drains up to two register writes per cycle onto the regfile write ports (port 1 older, port 2 younger).
- Exposes a pending-write lookup so decode can stall on RAW hazards against still-queued results.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- res_valid_0  input  1  lane 0 result valid (older).
- res_addr_0  input  5  lane 0 destination register.
- res_data_0  input  32  lane 0 result.
- res_valid_1  input  1  lane 1 result valid (younger).
- res_addr_1  input  5  lane 1 destination register.
- res_data_1  input  32  lane 1 result.
- res_ready  output  1  queue can accept both lanes this cycle.
- wb_stall  input  1  hold drain (regfile ports unavailable).
- we_1  output  1  write enable, older entry.
- writeaddr_1  output  5  write address, older entry.
- writedata_1  output  32  write data, older entry.
- we_2  output  1  write enable, younger entry.
- writeaddr_2  output  5  write address, younger entry.
- writedata_2  output  32  write data, younger entry.
- pend_addr_0  input  5  hazard lookup address 0.
- pend_addr_1  input  5  hazard lookup address 1.
- pend_hit_0  output  1  a queued entry targets pend_addr_0.
- pend_hit_1  output  1  a queued entry targets pend_addr_1.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset (rst low, async): head, tail, and count cleared; storage contents are don't-care. While rst is low: res_ready=0, we_1=we_2=0, pend_hit_*=0, count=0.
- Write-port outputs are driven combinationally from the head entries. writeaddr_*/writedata_* are forced to 0 whenever the matching we_* is 0.
- res_ready = (DEPTH - count >= 2). Uses the registered count only; same-cycle drain is not credited.
- Accept: a lane is enqueued when res_ready && res_valid_k && res_addr_k != 0.
  - Lane 0 is enqueued before lane 1.
  - If only lane 1 qualifies, it takes the single tail slot (compaction).
  - Results for r0 are discarded silently.
  - Valid with res_ready=0 is a producer protocol error; the result is not enqueued.
- Latency: a result accepted in cycle N can appear on we_* no earlier than cycle N+1.
- Drain, when wb_stall=0:
  - count >= 2: we_1 = head, we_2 = head+1, pop 2.
  - count == 1: we_1 = head, we_2 = 0, pop 1.
  - count == 0: no writes.
  - wb_stall=1: we_1 = we_2 = 0, no pop.
- Same address on both drained entries: both are issued; the regfile port-2 write (younger) wins. This is correct in-order semantics.
- Next state: count_next = count + enq_n - deq_n, with enq_n and deq_n in 0..2. Simultaneous enqueue and dequeue are legal. Head/tail advance modulo DEPTH and wrap seamlessly.
- Full: count == DEPTH-1 or DEPTH deasserts res_ready. Count can never exceed DEPTH.
- Hazard lookup: pend_hit_k = 1 iff any live entry (head..tail-1) has addr == pend_addr_k and pend_addr_k != 0. Combinational. Entries draining this cycle still count as hits; the regfile bypass covers them.
- A mid-operation reset discards all queued results. No writes are issued after rst falls.

Optional Feature:
- Macro WB_DRAIN_BYPASS_EN.
- Defined: when count == 0 and wb_stall == 0, accepted lanes drive we_1/we_2 directly in the same cycle (zero latency) and are not stored. When count == 1 with bypass, the head drains on port 1 and incoming lane 0 drives port 2; lane 1, if present, is enqueued.
- Undefined: minimum latency is 1 cycle as specified above.

Decomposition:
- Package wb_pkg:
  - REG_ADDR_W = 5, DATA_W = 32.
  - typedef struct packed wb_entry_t {addr[4:0], data[31:0]}.
  - function is_r0(addr).
- Sub-module wb_fifo_2w2r: circular buffer with 0/1/2 push and 0/1/2 pop per cycle, exposing head0/head1 entries, count, and a live-entry mask for the hazard compare.

Test Plan:
- Reset then idle: rst low → res_ready=0, we_1=we_2=0, count=0. Release → res_ready=1.
- Dual enqueue: lane0 {r5, 0xAAAA0005}, lane1 {r6, 0xBBBB0006} at cycle N → cycle N+1: we_1/r5/0xAAAA0005 and we_2/r6/0xBBBB0006; count returns to 0.
- r0 filter plus compaction: lane0 {r0, 0x1}, lane1 {r7, 0x77} → only r7 is written, on port 1; we_2=0; count peaks at 1.
- Same-address collision: lane0 {r9, 0x11}, lane1 {r9, 0x22} → both issued same cycle on ports 1/2; a regfile read of r9 afterwards returns 0x22.
- Stall and fill: wb_stall=1, push 2 per cycle with DEPTH=8 → res_ready drops once count=7 or 8. pend_hit_0=1 for a queued r12, 0 for r0. Release stall → drains 2 per cycle in FIFO order across pointer wrap.
- Reset mid-queue: count=5, pull rst low → we_*=0 immediately, count=0. After release no stale writes appear.
